dma_copy_master: RTL
====================

# dma_copy_master

Single-channel memory-to-memory DMA engine acting as AXI4 master, one word per transaction. It sits directly upstream of the team's AXI4 RAM slave, driving the slave's AW/W/B/AR/R channels. Each word is read from a source address, buffered internally, then written to a destination address. A software-style start/len interface launches transfers; busy, done and error report status.

## Interface
- ADDR_W, 32, address width (AXI addresses are byte addresses)
- DATA_W, 32, data width; fixed at 32, and wstrb is DATA_W/8 bits
- LEN_W, 16, width of the transfer length in words
- TIMEOUT, 255, handshake watchdog limit in cycles; used only with DMA_TIMEOUT_EN
- clk  in  1  the single clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle launch; ignored while busy
- src_addr  in  ADDR_W  source byte address, sampled on start
- dst_addr  in  ADDR_W  destination byte address, sampled on start
- len  in  LEN_W  number of 32-bit words, sampled on start
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout flag, cleared by the next accepted start
- awvalid/awaddr/awready  out/out/in  1/ADDR_W/1  write address channel
- wvalid/wdata/wstrb/wready  out/out/out/in  1/DATA_W/4/1  write data channel
- bvalid/bready  in/out  1/1  write response channel
- arvalid/araddr/arready  out/out/in  1/ADDR_W/1  read address channel
- rvalid/rdata/rready  in/in/out  1/DATA_W/1  read data channel

## Operation
- FSM states are IDLE, RD_REQ, RD_DATA, WR_REQ, WR_RESP and DONE.
- IDLE: on start, latch addresses with bits [1:0] forced to 0, and latch len.
  - len==0 goes to DONE with no bus traffic.
  - Otherwise go to RD_REQ.
- RD_REQ: arvalid=1 with araddr=src. Hold until the arready handshake, then drop arvalid and go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into the word buffer and go to WR_REQ.
- WR_REQ: assert awvalid and wvalid together, with awaddr=dst, wdata=buffer, wstrb=4'hF.
  - Each valid drops on its own ready.
  - awaddr and wdata stay stable until both handshakes complete.
  - Then go to WR_RESP.
- WR_RESP: bready=1. On bvalid, decrement the remaining count and advance src and dst by 4 (wraps modulo 2^ADDR_W).
  - Remaining==0 goes to DONE; otherwise go to RD_REQ.
- bvalid arriving before WR_RESP is not accepted (bready=0); the slave holds it.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- A valid is never held high after its handshake cycle. Back-to-back requests must not be issued into a slave whose ready toggles.
- start while busy or in DONE is ignored.
- Every output is registered.

## Timing
- Reset values: all valid/ready outputs, busy, done and error are 0; addresses, wdata and the counter are 0; wstrb is 0.
- Reset mid-transfer abandons the transaction. The FSM is in IDLE the cycle after reset is released.
- Cycle numbering: start sampled at edge 0; busy=1 and arvalid=1 from cycle 1.
- Against the zero-wait RAM slave, one word takes:
  - arready in cycle 2
  - rvalid/rready in cycle 3
  - aw/w valid in cycle 4, handshakes in cycle 5
  - bready in cycle 6, B handshake in cycle 6
- So one word costs 6 cycles, and an N-word transfer has done=1 in cycle 6N+1.
- busy is 1 from cycle 1 through the cycle of the final B handshake.
- len==0: done=1 in cycle 1 and busy never rises.
- Slave stalls extend only the stalled state; no data or address change occurs during a stall.

## Configuration
- DMA_TIMEOUT_EN defined:
  - A counter clears on entry to each of RD_REQ, RD_DATA, WR_REQ and WR_RESP.
  - It increments every cycle the state is unchanged.
  - Reaching TIMEOUT forces all valids/readies to 0, sets error=1 and goes to DONE (done pulse, busy=0).
- DMA_TIMEOUT_EN undefined: waits are unbounded and error is tied to 0.

## Structure
- The shared package dma_pkg holds:
  - the state enum dma_state_t
  - WORD_BYTES=4
  - the default widths
  - the full-strobe constant STRB_ALL=4'hF
- One sub-module, dma_hs_timer (watchdog counter with clear/enable/expired), is instantiated only under DMA_TIMEOUT_EN.
- The datapath and FSM stay in dma_copy_master.

## Test plan
- Reset pre-fill, then copy src=0x0, dst=0x100, len=1: RAM word 0x40 = 0xA5A50000; done=1 in cycle 7; exactly one AR, AW, W and B each.
- src=0x10, dst=0x2000, len=4: RAM words 0x800..0x803 = 0xA5A50004..0xA5A50007; done in cycle 25; awaddr steps by 4.
- len=0: done in cycle 1, no valid ever asserted; start while busy: second start ignored and the first transfer is unaffected.
- Random arready/rvalid/awready/wready/bvalid stalls: awaddr, wdata and araddr stay stable while valid; no valid persists past its handshake; data is correct.
- DMA_TIMEOUT_EN with TIMEOUT=8 and arready tied to 0: after 8 stall cycles, arvalid drops, error=1 and done pulses; the next start clears error.
- rst_n low during WR_REQ: the next cycle shows all outputs 0; a following start completes correctly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_copy_master block.
package dma_pkg;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_LEN_W   = 16;
  localparam int unsigned DEF_TIMEOUT = 255;

  localparam logic [3:0] STRB_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } dma_state_t;

endpackage

// File: rtl/dma_copy_master_if.sv
// AXI4 AW/W/B/AR/R subset used by the single-word copy master.
interface dma_copy_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

endinterface

// File: rtl/dma_hs_timer.sv
// Handshake watchdog: counts cycles since the last clear, flags when LIMIT is reached.
module dma_hs_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // expired_q tracks "the current cycle is the LIMIT-th one without a clear"
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d >= CNT_W'(LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/dma_copy_master.sv
// Single-channel memory-to-memory DMA, one AXI4 word per transaction.
// Optional handshake watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_copy_master
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  dma_copy_master_if.master axi
);
  localparam int unsigned       STRB_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              tmo_c;

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    wstrb_d   = wstrb_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & ALIGN_MASK;
          dst_d   = dst_addr_i & ALIGN_MASK;
          cnt_d   = len_i;
          error_d = 1'b0;
          if (len_i == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (arvalid_q && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready_q && axi.rvalid) begin
          buf_d     = axi.rdata;
          rready_d  = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wstrb_d   = STRB_W'(STRB_ALL);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave only once both have
        if (awvalid_q && axi.awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi.wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_q && axi.bvalid) begin
          bready_d = 1'b0;
          cnt_d    = cnt_q - LEN_W'(1);
          src_d    = src_q + ADDR_STEP;
          dst_d    = dst_q + ADDR_STEP;
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog abort: only when the wait state made no progress this cycle
    if (tmo_c && (state_d == state_q) &&
        (state_q inside {RD_REQ, RD_DATA, WR_REQ, WR_RESP})) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      error_d   = 1'b1;
      state_d   = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      wstrb_q   <= wstrb_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

`ifdef DMA_TIMEOUT_EN
  logic tmr_clr;
  assign tmr_clr = (state_d != state_q);

  dma_hs_timer #(
    .LIMIT(TIMEOUT)
  ) u_hs_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (state_q != IDLE),
    .expired_o(tmo_c)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_c          = 1'b0;
`endif

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = src_q;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = dst_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = buf_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.bready  = bready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
